sigma_mem_arbiter: RTL and testbench

Shares the single main-memory port between the CPU and the I/O processor (IOP). Each requester uses a request/acknowledge handshake. The block sequences a fixed-length memory cycle and returns read data to the winner. It sits between the CPU core, the IOP and the memory array. IOP has priority, with a bounded-starvation guarantee for the CPU.

---
 rtl/sigma_mem_pkg.sv | 26 ++
 rtl/sigma_mem_arb_select.sv | 24 ++
 rtl/sigma_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sigma_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_mem_pkg.sv
// Shared encodings and widths for the CPU/IOP main-memory arbiter.
// Bit numbering follows the machine's big-endian convention (bit 0 = MSB of a word).
package sigma_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int ADDR_W            = 17;   // address bits 15:31
   localparam int WORD_W            = 32;   // data bits 0:31
   localparam int ACCESS_CYCLES_DEF = 2;
   localparam int IOP_BURST_MAX_DEF = 4;

   // Width able to hold 0..burst_max inclusive.
   function automatic int streak_w(input int burst_max);
      return (burst_max < 1) ? 1 : $clog2(burst_max + 1);
   endfunction

   // Width able to hold 0..access_cycles-1.
   function automatic int cnt_w(input int access_cycles);
      return (access_cycles > 1) ? $clog2(access_cycles) : 1;
   endfunction

endpackage

// File: rtl/sigma_mem_arb_select.sv
// Grant policy: IOP has priority unless the CPU has sat through IOP_BURST_MAX IOP grants.
// Purely combinational; no state.
module sigma_mem_arb_select
   import sigma_mem_pkg::*;
#(
   parameter int IOP_BURST_MAX = IOP_BURST_MAX_DEF,
   parameter int SW            = streak_w(IOP_BURST_MAX)
) (
   input  logic          cpu_req,
   input  logic          iop_req,
   input  logic [SW-1:0] streak,
   output logic          grant_valid,
   output logic          grant_iop
);

   localparam logic [SW-1:0] STREAK_MAX = SW'(IOP_BURST_MAX);

   logic w_cpu_forced;

   assign w_cpu_forced = cpu_req && (streak == STREAK_MAX);
   assign grant_iop    = iop_req && !w_cpu_forced;
   assign grant_valid  = cpu_req || iop_req;

endmodule

// File: rtl/sigma_mem_arbiter.sv
// Shares the memory port between CPU and IOP: IDLE arbitrates, ACCESS holds the cycle,
// DONE carries the one-cycle ack. All outputs come straight from registers.
module sigma_mem_arbiter
   import sigma_mem_pkg::*;
#(
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
   parameter int IOP_BURST_MAX = IOP_BURST_MAX_DEF
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         cpu_req,
   input  logic         cpu_we,
   input  logic [15:31] cpu_addr,
   input  logic [0:31]  cpu_wdata,
   output logic         cpu_ack,
   output logic [0:31]  cpu_rdata,
   input  logic         iop_req,
   input  logic         iop_we,
   input  logic [15:31] iop_addr,
   input  logic [0:31]  iop_wdata,
   output logic         iop_ack,
   output logic [0:31]  iop_rdata,
   output logic         mem_en,
   output logic         mem_we,
   output logic [15:31] mem_addr,
   output logic [0:31]  mem_wdata,
   input  logic [0:31]  mem_rdata,
   output logic         busy,
   output logic         gnt_iop
);

   localparam int CW = cnt_w(ACCESS_CYCLES);
   localparam int SW = streak_w(IOP_BURST_MAX);
   localparam logic [CW-1:0] CNT_LOAD   = CW'(ACCESS_CYCLES - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(IOP_BURST_MAX);

   state_t         r_state,     w_state_nxt;
   logic [CW-1:0]  r_cnt,       w_cnt_nxt;
   logic [SW-1:0]  r_streak,    w_streak_nxt;
   logic           r_mem_en,    w_mem_en_nxt;
   logic           r_mem_we,    w_mem_we_nxt;
   logic [15:31]   r_mem_addr,  w_mem_addr_nxt;
   logic [0:31]    r_mem_wdata, w_mem_wdata_nxt;
   logic           r_gnt_iop,   w_gnt_iop_nxt;
   logic           r_busy,      w_busy_nxt;
   logic           r_cpu_ack,   w_cpu_ack_nxt;
   logic           r_iop_ack,   w_iop_ack_nxt;
   logic [0:31]    r_cpu_rdata, w_cpu_rdata_nxt;
   logic [0:31]    r_iop_rdata, w_iop_rdata_nxt;

   logic           w_grant_valid;
   logic           w_grant_iop;

   sigma_mem_arb_select #(
      .IOP_BURST_MAX (IOP_BURST_MAX),
      .SW            (SW)
   ) u_select (
      .cpu_req     (cpu_req),
      .iop_req     (iop_req),
      .streak      (r_streak),
      .grant_valid (w_grant_valid),
      .grant_iop   (w_grant_iop)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_streak    <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_gnt_iop   <= 1'b0;
         r_busy      <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_iop_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_iop_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_streak    <= w_streak_nxt;
         r_mem_en    <= w_mem_en_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_gnt_iop   <= w_gnt_iop_nxt;
         r_busy      <= w_busy_nxt;
         r_cpu_ack   <= w_cpu_ack_nxt;
         r_iop_ack   <= w_iop_ack_nxt;
         r_cpu_rdata <= w_cpu_rdata_nxt;
         r_iop_rdata <= w_iop_rdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_streak_nxt    = r_streak;
      w_mem_en_nxt    = r_mem_en;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_gnt_iop_nxt   = r_gnt_iop;
      w_busy_nxt      = r_busy;
      w_cpu_ack_nxt   = 1'b0;
      w_iop_ack_nxt   = 1'b0;
      w_cpu_rdata_nxt = r_cpu_rdata;
      w_iop_rdata_nxt = r_iop_rdata;

      case (r_state)
         IDLE: begin
            w_mem_en_nxt = 1'b0;
            w_mem_we_nxt = 1'b0;
            if (w_grant_valid) begin
               w_mem_en_nxt    = 1'b1;
               w_mem_we_nxt    = w_grant_iop ? iop_we    : cpu_we;
               w_mem_addr_nxt  = w_grant_iop ? iop_addr  : cpu_addr;
               w_mem_wdata_nxt = w_grant_iop ? iop_wdata : cpu_wdata;
               w_gnt_iop_nxt   = w_grant_iop;
               w_cnt_nxt       = CNT_LOAD;
               w_busy_nxt      = 1'b1;
               w_state_nxt     = ACCESS;
               // Streak only grows while the CPU is actually left waiting.
               if (w_grant_iop && cpu_req)
                  w_streak_nxt = (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
               else
                  w_streak_nxt = '0;
            end
         end
         ACCESS: begin
            if (r_cnt == '0) begin
               w_mem_en_nxt  = 1'b0;
               w_mem_we_nxt  = 1'b0;
               w_cpu_ack_nxt = !r_gnt_iop;
               w_iop_ack_nxt = r_gnt_iop;
               if (!r_mem_we) begin
                  if (r_gnt_iop) w_iop_rdata_nxt = mem_rdata;
                  else           w_cpu_rdata_nxt = mem_rdata;
               end
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt  = IDLE;
            w_mem_en_nxt = 1'b0;
            w_mem_we_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
         end
      endcase
   end

   assign cpu_ack   = r_cpu_ack;
   assign iop_ack   = r_iop_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign iop_rdata = r_iop_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;
   assign gnt_iop   = r_gnt_iop;

   a_one_ack: assert property (@(posedge clock) disable iff (reset) !(r_cpu_ack && r_iop_ack));

endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Directed bench for sigma_mem_arbiter: grants and acks are scored against queues of
// expected transactions filled by each scenario as it drives the requesters.
`timescale 1ns/1ps
module tb_sigma_mem_arbiter;
   import sigma_mem_pkg::*;

   localparam int AC = 2;
   localparam int BM = 2;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:31] cpu_addr = '0;
   logic [0:31]  cpu_wdata = '0;
   logic         cpu_ack;
   logic [0:31]  cpu_rdata;
   logic         iop_req = 1'b0, iop_we = 1'b0;
   logic [15:31] iop_addr = '0;
   logic [0:31]  iop_wdata = '0;
   logic         iop_ack;
   logic [0:31]  iop_rdata;
   logic         mem_en, mem_we;
   logic [15:31] mem_addr;
   logic [0:31]  mem_wdata;
   logic [0:31]  mem_rdata;
   logic         busy, gnt_iop;

   sigma_mem_arbiter #(.ACCESS_CYCLES(AC), .IOP_BURST_MAX(BM)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .iop_req(iop_req), .iop_we(iop_we), .iop_addr(iop_addr), .iop_wdata(iop_wdata),
      .iop_ack(iop_ack), .iop_rdata(iop_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .gnt_iop(gnt_iop)
   );

   always #5 clock = ~clock;

   function automatic logic [0:31] model_rd(input logic [15:31] a);
      if (a == 17'h00100) return 32'h12345678;
      return {a, 15'h2D5A} ^ 32'hC3C3_0F0F;
   endfunction

   assign mem_rdata = model_rd(mem_addr);

   typedef struct {
      logic         iop;
      logic         we;
      logic [15:31] addr;
      logic [0:31]  wdata;
   } txn_t;

   txn_t        gnt_q[$];
   txn_t        ack_q[$];
   txn_t        cur;
   int          cyc = 0, gnt_cyc = 0, en_cnt = 0;
   logic        prev_en = 1'b0;
   int          cpu_left = 0, iop_left = 0;
   logic [0:31] exp_cpu_rd = '0, exp_iop_rd = '0;
   int          n_cmp = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, score grants/acks, retire requests on ack.
   task automatic step();
      txn_t t;
      @(negedge clock);
      cyc++;
      chk("busy", 32'(busy), 32'(mem_en | cpu_ack | iop_ack));
      chk("one_ack", 32'(cpu_ack & iop_ack), 32'd0);
      if (mem_en && !prev_en) begin
         if (gnt_q.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
         else begin
            cur = gnt_q.pop_front();
            chk("gnt_iop", 32'(gnt_iop), 32'(cur.iop));
            ack_q.push_back(cur);
            gnt_cyc = cyc;
            en_cnt  = 0;
         end
      end
      if (mem_en) begin
         en_cnt++;
         chk("mem_we", 32'(mem_we), 32'(cur.we));
         chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
         chk("mem_wdata", mem_wdata, cur.wdata);
      end else begin
         chk("mem_we_idle", 32'(mem_we), 32'd0);
      end
      if (cpu_ack || iop_ack) begin
         if (ack_q.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
         else begin
            t = ack_q.pop_front();
            chk("ack_who", 32'(iop_ack), 32'(t.iop));
            chk("ack_latency", 32'(cyc - gnt_cyc), 32'(AC));
            chk("en_cycles", 32'(en_cnt), 32'(AC));
            if (!t.we) begin
               if (t.iop) exp_iop_rd = model_rd(t.addr);
               else       exp_cpu_rd = model_rd(t.addr);
            end
            chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
            chk("iop_rdata", iop_rdata, exp_iop_rd);
            if (t.iop) begin
               iop_left--;
               if (iop_left <= 0) iop_req = 1'b0;
            end else begin
               cpu_left--;
               if (cpu_left <= 0) cpu_req = 1'b0;
            end
         end
      end
      prev_en = mem_en;
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while ((gnt_q.size() != 0 || ack_q.size() != 0 || cpu_req || iop_req || busy) && n < budget) begin
         step();
         n++;
      end
      n_cmp++;
      assert (n < budget) else begin
         n_fail++;
         $error("FAIL timeout: waited %0d cycles, limit %0d", n, budget);
      end
      step();
   endtask

   task automatic wait_grant(input int budget);
      int n = 0;
      while (ack_q.size() == 0 && n < budget) begin
         step();
         n++;
      end
      n_cmp++;
      assert (n < budget) else begin
         n_fail++;
         $error("FAIL grant_timeout: waited %0d cycles, limit %0d", n, budget);
      end
   endtask

   task automatic drive_cpu(input logic we, input logic [15:31] a, input logic [0:31] d, input int cnt);
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_left = cnt; cpu_req = 1'b1;
   endtask

   task automatic drive_iop(input logic we, input logic [15:31] a, input logic [0:31] d, input int cnt);
      iop_we = we; iop_addr = a; iop_wdata = d; iop_left = cnt; iop_req = 1'b1;
   endtask

   initial begin
      // Reset state
      #2 reset = 1'b1;
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_acks", 32'({cpu_ack, iop_ack}), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_iop_rdata", iop_rdata, 32'd0);
      chk("rst_busy_gnt", 32'({busy, gnt_iop}), 32'd0);
      step();
      step();
      reset = 1'b0;
      step();

      // CPU read
      gnt_q.push_back('{1'b0, 1'b0, 17'h00100, 32'h0});
      drive_cpu(1'b0, 17'h00100, 32'h0, 1);
      run_until_idle(40);
      chk("cpu_read_data", cpu_rdata, 32'h12345678);

      // IOP write: iop_rdata must stay at its reset value
      gnt_q.push_back('{1'b1, 1'b1, 17'h1FFFF, 32'hDEADBEEF});
      drive_iop(1'b1, 17'h1FFFF, 32'hDEADBEEF, 1);
      run_until_idle(40);
      chk("iop_write_rdata", iop_rdata, 32'h0);

      // Simultaneous requests: IOP first, CPU at the next IDLE edge
      gnt_q.push_back('{1'b1, 1'b0, 17'h00300, 32'h0});
      gnt_q.push_back('{1'b0, 1'b0, 17'h00200, 32'h0});
      drive_iop(1'b0, 17'h00300, 32'h0, 1);
      drive_cpu(1'b0, 17'h00200, 32'h0, 1);
      run_until_idle(60);

      // Starvation bound with BM=2: I, I, C, I, I, C
      for (int k = 0; k < 6; k++) begin
         if (k % 3 == 2) gnt_q.push_back('{1'b0, 1'b1, 17'h00800, 32'hCAFEF00D});
         else            gnt_q.push_back('{1'b1, 1'b0, 17'h00700, 32'h0});
      end
      drive_iop(1'b0, 17'h00700, 32'h0, 4);
      drive_cpu(1'b1, 17'h00800, 32'hCAFEF00D, 2);
      run_until_idle(120);

      // Request dropped during the first ACCESS cycle still completes
      gnt_q.push_back('{1'b0, 1'b0, 17'h00400, 32'h0});
      drive_cpu(1'b0, 17'h00400, 32'h0, 1);
      wait_grant(20);
      cpu_req = 1'b0;
      run_until_idle(40);

      // Reset in the second ACCESS cycle of an IOP grant taken over a waiting CPU
      gnt_q.push_back('{1'b1, 1'b0, 17'h00500, 32'h0});
      drive_iop(1'b0, 17'h00500, 32'h0, 1);
      drive_cpu(1'b0, 17'h00600, 32'h0, 1);
      wait_grant(20);
      chk("streak_pre_reset", 32'(dut.r_streak), 32'd1);
      step();
      reset = 1'b1;
      #1;
      chk("abort_mem_en", 32'(mem_en), 32'd0);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      gnt_q.delete();
      ack_q.delete();
      iop_req = 1'b0; cpu_req = 1'b0; iop_left = 0; cpu_left = 0;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("post_reset_state", 32'(dut.r_state), 32'(IDLE));
      chk("post_reset_streak", 32'(dut.r_streak), 32'd0);
      for (int k = 0; k < 5; k++) step();
      chk("post_reset_acks", 32'({cpu_ack, iop_ack}), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
